// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the R/I/S-type RISC-V core, with a retired-instruction counter.
// Optional feature macro: MULTICYCLE_ILLEGAL_TRAP_EN (illegal opcodes park in TRAP until reset).
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       imm_sel,
  output logic             alu_src_imm,
  output logic [1:0]       alu_op,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal_inst
);

  localparam logic [1:0] IMM_I    = 2'b00;
  localparam logic [1:0] IMM_S    = 2'b01;
  localparam logic [1:0] IMM_ZERO = 2'b10;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_R    = 2'b01;
  localparam logic [1:0] ALU_IA   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_R, C_IA, C_LD, C_ST, C_ILL
  } cls_t;

  state_t     state_q, state_d;
  cls_t       cls_q, cls_d, dec_cls;
  logic [4:0] rd_q, rd_d;

  // Only opcode and rd are consumed here; the rest of the word feeds the datapath.
  logic unused_inst;
  assign unused_inst = &{1'b0, inst[31:12]};

  // Opcode classification, latched on the DECODE -> next edge.
  always_comb begin
    dec_cls = C_ILL;
    case (inst[6:0])
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_IA;
      7'b0000011: dec_cls = C_LD;
      7'b0100011: dec_cls = C_ST;
      default:    dec_cls = C_ILL;
    endcase
  end

  // State, latched class/rd and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_NONE;
      rd_q    <= 5'd0;
      instret <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      rd_q    <= rd_d;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  // Next-state and control decode; FETCH/MEM handshakes respond within the ready cycle.
  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    rd_d         = rd_q;
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    imm_sel      = IMM_ZERO;
    alu_src_imm  = 1'b0;
    alu_op       = ALU_ADD;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 1'b0;
    retire       = 1'b0;
    illegal_inst = 1'b0;

    case (state_q)
      S_IDLE: begin
        imm_sel = 2'b00;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        imm_sel = 2'b00;
        cls_d   = dec_cls;
        rd_d    = inst[11:7];
        if (dec_cls == C_ILL) begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_R:  begin alu_op = ALU_R; state_d = S_WB; end
          C_IA: begin imm_sel = IMM_I; alu_src_imm = 1'b1; alu_op = ALU_IA; state_d = S_WB; end
          C_LD: begin imm_sel = IMM_I; alu_src_imm = 1'b1; state_d = S_MEM; end
          C_ST: begin imm_sel = IMM_S; alu_src_imm = 1'b1; state_d = S_MEM; end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        // Address operands held from EXEC so the memory address stays stable.
        dmem_req    = 1'b1;
        dmem_we     = (cls_q == C_ST);
        imm_sel     = (cls_q == C_ST) ? IMM_S : IMM_I;
        alu_src_imm = 1'b1;
        if (dmem_ready) begin
          if (cls_q == C_ST) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we  = (rd_q != 5'd0);
        wb_sel  = (cls_q == C_LD);
        retire  = 1'b1;
        state_d = S_FETCH;
        if (cls_q == C_IA) begin
          imm_sel     = IMM_I;
          alu_src_imm = 1'b1;
          alu_op      = ALU_IA;
        end else if (cls_q == C_R) begin
          alu_op = ALU_R;
        end
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP: begin
        imm_sel      = 2'b00;
        illegal_inst = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a per-instruction cycle-trace model predicts every cycle's controls.
module tb_multicycle_ctrl;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [31:0]      inst;
  logic             imem_ready, dmem_ready;
  logic             imem_req, ir_we, pc_we, alu_src_imm, dmem_req, dmem_we;
  logic             reg_we, wb_sel, retire, illegal_inst;
  logic [1:0]       imm_sel, alu_op;
  logic [CNT_W-1:0] instret;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .imm_sel(imm_sel),
    .alu_src_imm(alu_src_imm), .alu_op(alu_op), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_we(reg_we), .wb_sel(wb_sel), .retire(retire), .instret(instret),
    .illegal_inst(illegal_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             rst_n;
    logic [31:0]      inst;
    logic             irdy;
    logic             drdy;
    logic [13:0]      outs;
    logic [CNT_W-1:0] cnt;
  } step_t;

  step_t            plan_q[$];
  int unsigned      checks;
  int unsigned      failures;
  logic [31:0]      cur_inst;
  logic [CNT_W-1:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Control vector order: imem_req ir_we pc_we imm_sel alu_src_imm alu_op dmem_req dmem_we reg_we wb_sel retire illegal
  function automatic logic [13:0] ov(input logic ireq, input logic irw, input logic pcw,
                                     input logic [1:0] imm, input logic src, input logic [1:0] op,
                                     input logic dreq, input logic dwe, input logic rwe,
                                     input logic wbs, input logic ret, input logic ill);
    return {ireq, irw, pcw, imm, src, op, dreq, dwe, rwe, wbs, ret, ill};
  endfunction

  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rst, input logic [31:0] ins, input logic ir,
                      input logic dr, input logic [13:0] o);
    step_t s;
    s.rst_n = rst; s.inst = ins; s.irdy = ir; s.drdy = dr; s.outs = o; s.cnt = m_cnt;
    plan_q.push_back(s);
    if (!rst) m_cnt = '0;
    else if (o[1]) m_cnt = m_cnt + CNT_W'(1);
  endtask

  // Expected cycle trace of one instruction, from FETCH up to (not including) the next FETCH.
  task automatic plan_inst(input logic [31:0] ins, input int iw, input int dw);
    int         cls;  // 0 R, 1 IA, 2 LD, 3 ST, 4 illegal
    logic [1:0] imm, op, wimm, wop;
    logic       src, wsrc, rd_nz;
    case (ins[6:0])
      7'h33:   cls = 0;
      7'h13:   cls = 1;
      7'h03:   cls = 2;
      7'h23:   cls = 3;
      default: cls = 4;
    endcase
    rd_nz = (ins[11:7] != 5'd0);
    for (int k = 0; k < iw; k++)
      push(1'b1, cur_inst, 1'b0, noise(), ov(1,0,0,2'b10,0,2'b00,0,0,0,0,0,0));
    push(1'b1, cur_inst, 1'b1, noise(), ov(1,1,1,2'b10,0,2'b00,0,0,0,0,0,0));
    cur_inst = ins;
    push(1'b1, ins, noise(), noise(), 14'd0);
    if (cls == 4) begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      for (int k = 0; k < int'($urandom_range(1, 4)); k++)
        push(1'b1, ins, noise(), noise(), ov(0,0,0,2'b00,0,2'b00,0,0,0,0,0,1));
      push(1'b0, ins, noise(), noise(), ov(0,0,0,2'b00,0,2'b00,0,0,0,0,0,1));
      push(1'b1, ins, noise(), noise(), 14'd0);
`endif
      return;
    end
    case (cls)
      0:       begin imm = 2'b10; src = 1'b0; op = 2'b01; end
      1:       begin imm = 2'b00; src = 1'b1; op = 2'b10; end
      2:       begin imm = 2'b00; src = 1'b1; op = 2'b00; end
      default: begin imm = 2'b01; src = 1'b1; op = 2'b00; end
    endcase
    push(1'b1, ins, noise(), noise(), ov(0,0,0,imm,src,op,0,0,0,0,0,0));
    if (cls >= 2) begin
      for (int k = 0; k < dw; k++)
        push(1'b1, ins, noise(), 1'b0, ov(0,0,0,imm,src,op,1,cls == 3,0,0,0,0));
      push(1'b1, ins, noise(), 1'b1, ov(0,0,0,imm,src,op,1,cls == 3,0,0,cls == 3,0));
      if (cls == 3) return;
    end
    if (cls == 1) begin wimm = imm; wsrc = src; wop = op; end
    else if (cls == 0) begin wimm = 2'b10; wsrc = 1'b0; wop = 2'b01; end
    else begin wimm = 2'b10; wsrc = 1'b0; wop = 2'b00; end
    push(1'b1, ins, noise(), noise(), ov(0,0,0,wimm,wsrc,wop,0,0,rd_nz,cls == 2,1,0));
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  opc;
    logic [6:0]  ill_ops [4];
    ill_ops = '{7'h7F, 7'h37, 7'h63, 7'h00};
    r = $urandom;
    case ($urandom_range(0, 4))
      0:       opc = 7'h33;
      1:       opc = 7'h13;
      2:       opc = 7'h03;
      3:       opc = 7'h23;
      default: opc = ill_ops[$urandom_range(0, 3)];
    endcase
    if ($urandom_range(0, 5) == 0) r[11:7] = 5'd0;
    return {r[31:7], opc};
  endfunction

  initial begin
    logic [13:0] act;
    checks = 0; failures = 0; m_cnt = '0; cur_inst = 32'h0;
    rst_n = 1'b0; inst = 32'h0; imem_ready = 1'b0; dmem_ready = 1'b0;

    push(1'b1, 32'h0, 1'b0, 1'b0, 14'd0);          // IDLE right after reset release
    plan_inst(32'h00700293, 0, 0);                  // ADDI x5,x0,7
    plan_inst(32'h0020A423, 0, 3);                  // SW x2,8(x1), 3 wait cycles
    plan_inst(32'h0000A183, 2, 0);                  // LW x3,0(x1), 2 fetch waits
    plan_inst(32'h00208033, 0, 0);                  // ADD x0 -> no reg_we, still retires
    for (int n = 0; n < 60; n++)
      plan_inst(rand_inst(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    plan_inst(32'h0000007F, 0, 0);                  // illegal opcode
    plan_inst(32'h00700293, 1, 0);                  // recovers afterwards

    repeat (3) @(posedge clk);
    #1;
    foreach (plan_q[i]) begin
      rst_n      = plan_q[i].rst_n;
      inst       = plan_q[i].inst;
      imem_ready = plan_q[i].irdy;
      dmem_ready = plan_q[i].drdy;
      @(negedge clk);
      act = {imem_req, ir_we, pc_we, imm_sel, alu_src_imm, alu_op,
             dmem_req, dmem_we, reg_we, wb_sel, retire, illegal_inst};
      check($sformatf("ctrl@%0d", i), 32'(act), 32'(plan_q[i].outs));
      check($sformatf("instret@%0d", i), 32'(instret), 32'(plan_q[i].cnt));
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
